fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Dequeue-side reader for the memio FIFOs. It drains a FIFO read port that returns registered data one cycle after the dequeue, and presents the words as a valid/ready stream.
- Lives in the consumer clock domain and connects directly to a FIFO's deq_clock-side signals.
- Keeps full throughput (one word per cycle) despite the FIFO read latency by tracking one in-flight read and buffering in a 2-entry skid store.

Parameters:
- WIDTH, 8, data word width; must match the attached FIFO.
- FLUSH_EN, 1, when 0 the flush input is ignored (tie-off synthesis option).

Ports:
- clock  input  1  sole clock; must be the FIFO deq_clock.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO data_out; valid the cycle after a dequeue issued while fifo_empty=0.
- fifo_dequeue  output  1  FIFO dequeue strobe.
- m_valid  output  1  stream word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  WIDTH  stream word; the head entry.
- flush  input  1  discard all buffered and in-flight words.
- occupancy  output  2  buffered word count, 0..2, excluding the in-flight word.

Behaviour:
- Reset (reset=0 at a clock edge):
  - occupancy=0, in-flight flag=0, m_valid=0, m_data=0.
  - fifo_dequeue is forced 0 combinationally while reset=0.
  - Reset mid-operation drops buffered and in-flight words. An in-flight word arriving on the cycle after reset is ignored.
- Definitions: pop = m_valid & m_ready; issue = fifo_dequeue.
- Dequeue rule: fifo_dequeue = reset & !fifo_empty & !flush & ((occupancy + inflight - pop) < 2).
  - This is a combinational path from m_ready to fifo_dequeue. It is intentional and documented for timing.
  - fifo_dequeue is never asserted while fifo_empty=1. The FIFO's pessimistic empty flag means every issued dequeue returns a word.
- In-flight flag: next inflight = issue. Capture fifo_data on the edge following the cycle in which inflight=1 (latency exactly 1).
- Skid store: two registers, head and tail, in FIFO order.
  - m_data = head; m_valid = (occupancy != 0).
  - Capture with no pop: the word goes to head if occupancy=0, else to tail.
  - Capture with pop: if occupancy=1, the word goes to head; if occupancy=2, tail moves to head and the new word goes to tail.
  - Pop with no capture: tail moves to head; occupancy decrements.
  - Capture with pop in the same cycle is legal and leaves occupancy unchanged.
- Occupancy never exceeds 2. Reaching 3 is a design error and is asserted in simulation.
- m_valid/m_data must stay stable while m_valid=1 & m_ready=0.
- Flush (FLUSH_EN=1, flush=1 at an edge):
  - occupancy becomes 0 and inflight becomes 0.
  - A word returning that cycle is discarded.
  - fifo_dequeue is 0 during flush.
  - Flush has priority over capture and pop; pop during flush is not counted.
- Throughput: with a non-empty FIFO and m_ready held at 1, the reader sustains 1 word per cycle after a 2-cycle startup. The first m_valid appears 2 cycles after the first cycle with fifo_empty=0: dequeue in cycle N, capture at edge N+1, m_valid in cycle N+1 registered, visible N+2.

Decomposition:
- memio_pkg (shared): occupancy encoding localparams OCC_ZERO/OCC_ONE/OCC_TWO and a 2-bit occ_t typedef, reused by other FIFO adapters.
- One natural sub-module: skid_buffer2, the 2-entry head/tail store with capture/pop/flush inputs and occupancy output. fifo_reader contains only the dequeue and in-flight control around it.

Test Plan:
- Reset: hold reset=0 for 3 cycles with fifo_empty=0 -> fifo_dequeue=0, m_valid=0, m_data=0, occupancy=0 throughout.
- Streaming: FIFO model holds 0x11,0x22,0x33,0x44 and m_ready=1 ->
  - fifo_dequeue high in 4 consecutive cycles;
  - m_data 0x11..0x44 on 4 consecutive cycles, starting 2 cycles after the first dequeue.
- Back-pressure: m_ready=0 with 5 words queued ->
  - exactly 2 dequeues, occupancy=2, m_data held at first word;
  - release m_ready -> remaining 3 delivered in order with no loss or duplication.
- Simultaneous capture and pop at occupancy=2: m_ready toggling 1,0,1 ->
  - occupancy never exceeds 2;
  - output order matches input order 0xA0..0xA7.
- Empty boundary: fifo_empty rises after 1 word -> exactly one dequeue, m_valid for one accepted word, then m_valid=0.
- Flush mid-flight: assert flush in the cycle after a dequeue, with occupancy=1 -> next cycle occupancy=0, m_valid=0, and the returning word is not delivered.

Source files
------------

// File: rtl/memio_pkg.sv
// Shared occupancy encoding for the memio FIFO adapters.
// Keep this in sync with every adapter that reports a 0..2 buffered-word count.
package memio_pkg;
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_ZERO = 2'd0;
  localparam occ_t OCC_ONE  = 2'd1;
  localparam occ_t OCC_TWO  = 2'd2;
endpackage

// File: rtl/fifo_reader_if.sv
// FIFO dequeue port plus the outgoing valid/ready stream of fifo_reader.
// The master modport is the reader; the slave modport is the FIFO and consumer side.
interface fifo_reader_if #(parameter int WIDTH = 8);
  import memio_pkg::*;

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_dequeue;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             flush;
  occ_t             occupancy;

  modport master (
    input  fifo_empty, fifo_data, m_ready, flush,
    output fifo_dequeue, m_valid, m_data, occupancy
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready, flush,
    input  fifo_dequeue, m_valid, m_data, occupancy
  );
endinterface

// File: rtl/fifo_reader_skid_buffer2.sv
// Two-entry head/tail store in FIFO order; head is the presented word.
// Flush empties the store and overrides both capture and pop.
module skid_buffer2
  import memio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] cap_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             vld_o,
  output occ_t             occ_o
);
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  occ_t             occ_q, occ_d;
  logic             pop;

  assign pop = pop_i & (occ_q != OCC_ZERO);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = OCC_ZERO;
    end else begin
      case ({capture_i, pop})
        2'b10: begin
          if (occ_q == OCC_ZERO) head_d = cap_dat_i;
          else                   tail_d = cap_dat_i;
          occ_d = occ_q + 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever stays buffered.
          if (occ_q == OCC_ONE) begin
            head_d = cap_dat_i;
          end else begin
            head_d = tail_q;
            tail_d = cap_dat_i;
          end
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_ZERO;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = head_q;
  assign vld_o  = (occ_q != OCC_ZERO);
  assign occ_o  = occ_q;

  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) occ_q != 2'd3);
endmodule

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream at full rate.
// fifo_dequeue depends combinationally on m_ready so a pop frees a slot the same cycle.
module fifo_reader
  import memio_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit FLUSH_EN = 1'b1
) (
  input logic          clock,
  input logic          reset,
  fifo_reader_if.master bus
);
  logic       inflight_q, inflight_d;
  logic       flush_eff;
  logic       pop;
  logic       issue;
  logic [2:0] pending;
  occ_t       occ;

  assign flush_eff = FLUSH_EN & bus.flush;
  assign pop       = bus.m_valid & bus.m_ready;

  // Words already committed to the store once this cycle's pop is accounted for.
  assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = reset & ~bus.fifo_empty & ~flush_eff & (pending < 3'd2);

  assign inflight_d = issue;

  always_ff @(posedge clock) begin
    if (!reset) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  skid_buffer2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i     (clock),
    .rst_ni    (reset),
    .capture_i (inflight_q),
    .cap_dat_i (bus.fifo_data),
    .pop_i     (pop),
    .flush_i   (flush_eff),
    .head_o    (bus.m_data),
    .vld_o     (bus.m_valid),
    .occ_o     (occ)
  );

  assign bus.fifo_dequeue = issue;
  assign bus.occupancy    = occ;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: vector table, corner-case sequences and randomized traffic
// checked against a queue model of the buffered words.
module tb_fifo_reader;
  import memio_pkg::*;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fifo_reader_if #(.WIDTH(W)) bus();

  fifo_reader #(.WIDTH(W), .FLUSH_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         rst_n;
    bit         rdy;
    bit         fl;
    bit         exp_deq;
    bit         exp_vld;
    bit         chk_dat;
    logic [7:0] exp_dat;
    int         exp_occ;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] mdl_q[$];
  logic [7:0] got_q[$];
  bit         mdl_infl;
  logic [7:0] infl_word;
  bit         force_empty;
  bit         chk_en;
  int         n_deq;
  int         max_occ;
  bit         prev_stall;
  logic [7:0] prev_dat;

  logic       s_deq, s_vld;
  logic [7:0] s_dat;
  occ_t       s_occ;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle; inputs must already be set (called just after a negedge).
  task automatic cycle();
    bit exp_pop;
    bit exp_deq;
    int pend;
    bus.fifo_empty = force_empty || (fifo_q.size() == 0);
    #1;
    s_deq = bus.fifo_dequeue;
    s_vld = bus.m_valid;
    s_dat = bus.m_data;
    s_occ = bus.occupancy;
    exp_pop = (mdl_q.size() != 0) && bus.m_ready;
    pend    = mdl_q.size() + int'(mdl_infl) - int'(exp_pop);
    exp_deq = reset && !bus.fifo_empty && !bus.flush && (pend < 2);
    if (chk_en) begin
      chk("deq_rule", 32'(s_deq), 32'(exp_deq));
      chk("valid", 32'(s_vld), 32'(mdl_q.size() != 0));
      chk("occupancy", 32'(s_occ), 32'(mdl_q.size()));
      if (mdl_q.size() != 0) chk("data", 32'(s_dat), 32'(mdl_q[0]));
      if (prev_stall) chk("stable", 32'({s_vld, s_dat}), 32'({1'b1, prev_dat}));
    end
    if (32'(s_occ) > max_occ) max_occ = 32'(s_occ);
    if (s_deq === 1'b1) n_deq++;
    if (s_vld === 1'b1 && bus.m_ready && reset && !bus.flush) got_q.push_back(s_dat);
    prev_stall = reset && !bus.flush && (s_vld === 1'b1) && !bus.m_ready;
    prev_dat   = s_dat;
    @(posedge clock);
    if (!reset || bus.flush) begin
      mdl_q.delete();
      mdl_infl = 1'b0;
    end else begin
      if (exp_pop) void'(mdl_q.pop_front());
      if (mdl_infl) mdl_q.push_back(infl_word);
      mdl_infl = (s_deq === 1'b1);
    end
    #1;
    if (s_deq === 1'b1 && fifo_q.size() != 0) begin
      infl_word     = fifo_q.pop_front();
      bus.fifo_data = infl_word;
    end
    @(negedge clock);
  endtask

  initial begin
    reset         = 1'b0;
    bus.m_ready   = 1'b0;
    bus.flush     = 1'b0;
    bus.fifo_data = '0;
    bus.fifo_empty = 1'b1;
    force_empty   = 1'b0;
    chk_en        = 1'b0;
    mdl_infl      = 1'b0;
    infl_word     = '0;
    prev_stall    = 1'b0;
    prev_dat      = '0;
    n_deq         = 0;
    max_occ       = 0;

    //         rst rdy fl deq vld cdat dat    occ
    tbl[0] = '{0,  1,  0, 0,  0,  1,   8'h00, 0};
    tbl[1] = '{0,  1,  0, 0,  0,  1,   8'h00, 0};
    tbl[2] = '{0,  1,  0, 0,  0,  1,   8'h00, 0};
    tbl[3] = '{1,  1,  0, 1,  0,  1,   8'h00, 0};
    tbl[4] = '{1,  1,  0, 1,  0,  1,   8'h00, 0};
    tbl[5] = '{1,  1,  0, 1,  1,  1,   8'h11, 1};
    tbl[6] = '{1,  1,  0, 1,  1,  1,   8'h22, 1};
    tbl[7] = '{1,  1,  0, 0,  1,  1,   8'h33, 1};
    tbl[8] = '{1,  1,  0, 0,  1,  1,   8'h44, 1};
    tbl[9] = '{1,  1,  0, 0,  0,  0,   8'h00, 0};

    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h11 * (i + 1)));
    @(negedge clock);
    cycle();
    chk_en = 1'b1;

    // Reset hold then 4-word stream
    for (int i = 0; i < 10; i++) begin
      reset       = tbl[i].rst_n;
      bus.m_ready = tbl[i].rdy;
      bus.flush   = tbl[i].fl;
      cycle();
      chk($sformatf("vec%0d_deq", i), 32'(s_deq), 32'(tbl[i].exp_deq));
      chk($sformatf("vec%0d_vld", i), 32'(s_vld), 32'(tbl[i].exp_vld));
      chk($sformatf("vec%0d_occ", i), 32'(s_occ), 32'(tbl[i].exp_occ));
      if (tbl[i].chk_dat) chk($sformatf("vec%0d_dat", i), 32'(s_dat), 32'(tbl[i].exp_dat));
    end

    // Back-pressure with 5 words queued
    got_q.delete();
    n_deq = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h51 + i));
    bus.m_ready = 1'b0;
    repeat (6) cycle();
    chk("bp_deqs", 32'(n_deq), 32'd2);
    chk("bp_occ", 32'(s_occ), 32'd2);
    chk("bp_head", 32'(s_dat), 32'h51);
    chk("bp_none", 32'(got_q.size()), 32'd0);
    bus.m_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'(8'h51 + i));

    // Ready toggling while the store is full
    got_q.delete();
    max_occ = 0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 24; i++) begin
      bus.m_ready = (i % 2 == 0);
      cycle();
    end
    bus.m_ready = 1'b1;
    repeat (8) cycle();
    chk("sim_maxocc", 32'(max_occ <= 2), 32'd1);
    chk("sim_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("sim_order%0d", i), 32'(got_q[i]), 32'(8'hA0 + i));

    // FIFO runs dry after one word
    got_q.delete();
    n_deq = 0;
    fifo_q.push_back(8'h77);
    repeat (5) cycle();
    chk("empty_deqs", 32'(n_deq), 32'd1);
    chk("empty_count", 32'(got_q.size()), 32'd1);
    chk("empty_word", 32'(got_q[0]), 32'h77);
    chk("empty_vld", 32'(s_vld), 32'd0);

    // Flush one cycle after a dequeue with one word buffered
    got_q.delete();
    fifo_q.push_back(8'hB1);
    fifo_q.push_back(8'hB2);
    fifo_q.push_back(8'hB3);
    bus.m_ready = 1'b0;
    cycle();
    cycle();
    bus.flush = 1'b1;
    cycle();
    chk("fl_pre_occ", 32'(s_occ), 32'd1);
    chk("fl_deq", 32'(s_deq), 32'd0);
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    cycle();
    chk("fl_occ", 32'(s_occ), 32'd0);
    chk("fl_vld", 32'(s_vld), 32'd0);
    repeat (4) cycle();
    chk("fl_count", 32'(got_q.size()), 32'd1);
    chk("fl_word", 32'(got_q[0]), 32'hB3);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0 && fifo_q.size() < 8) fifo_q.push_back(8'($urandom));
      bus.m_ready = ($urandom_range(0, 2) != 0);
      bus.flush   = ($urandom_range(0, 40) == 0);
      force_empty = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 150) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
